// File: rtl/pc_irq_pkg.sv
// pc_irq_pkg: shared types and constants for the PC/interrupt sequencer.
package pc_irq_pkg;
    function automatic int level_width(input int num_irq);
        return $clog2(num_irq + 1);
    endfunction
    localparam int PC_W = 16;
    localparam int IRQ_N = 8;
    localparam int LEVEL_W = level_width(IRQ_N);
    localparam logic [LEVEL_W-1:0] LEVEL_IDLE = LEVEL_W'(IRQ_N);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [LEVEL_W-1:0] level;
    } stack_entry_t;
endpackage

// File: rtl/pc_irq_sequencer_ret_stack.sv
// ret_stack: LIFO of saved return state; push ignored when full, pop ignored when empty.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [CW-1:0] count;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign top = mem[AW'(count - 1'b1)];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (push && !full) count <= count + 1'b1;
        else if (pop && !empty) count <= count - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[AW'(count)] <= din;
    end
endmodule

// File: rtl/pc_irq_sequencer.sv
// pc_irq_sequencer: fetch PC generator with branches, stalls and nested prioritised interrupts.
module pc_irq_sequencer
    import pc_irq_pkg::*;
#(
    parameter int N = PC_W,
    parameter int NUM_IRQ = IRQ_N,
    parameter int STACK_DEPTH = 4,
    parameter logic [N-1:0] VECTOR_BASE = 'h00F0,
    parameter int VECTOR_STRIDE = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               Branch_taken,
    input  logic [N-1:0]       Branch_target,
    input  logic               Reti,
    input  logic               Inr_Check,
    input  logic [NUM_IRQ-1:0] Inr,
    output logic [N-1:0]       PC_out,
    output logic [NUM_IRQ-1:0] Irq_ack,
    output logic               In_service,
    output logic               Stack_full,
    output logic               Stack_error
);
    localparam int LW = level_width(NUM_IRQ);
    localparam logic [LW-1:0] IDLE = LW'(NUM_IRQ);
    typedef struct packed {
        logic [N-1:0]  pc;
        logic [LW-1:0] level;
    } entry_t;
    logic [LW-1:0] level, idx;
    logic found, accept, pop, full, empty;
    entry_t top_e, push_e;
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (Inr[i] && LW'(i) < level) begin
                found = 1'b1;
                idx = LW'(i);
            end
        end
    end
    assign accept = Inr_Check && found && !full && !Reti && !Stall;
    assign pop = Reti && !Stall && !empty;
    assign Irq_ack = accept ? NUM_IRQ'(1) << idx : '0;
    // An in-flight branch is what the handler returns to
    assign push_e = {Branch_taken ? Branch_target : PC_out + N'(1), level};
    assign In_service = !empty;
    assign Stack_full = full;
    ret_stack #(.DEPTH(STACK_DEPTH), .W(N + LW)) u_stack (
        .clk(Clock),
        .rst(Reset),
        .push(accept),
        .pop(pop),
        .din(push_e),
        .top(top_e),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            PC_out <= '0;
            level <= IDLE;
            Stack_error <= 1'b0;
        end else if (!Stall) begin
            if (pop) begin
                PC_out <= top_e.pc;
                level <= top_e.level;
            end else if (Reti) begin
                Stack_error <= 1'b1;
                PC_out <= PC_out + N'(1);
            end else if (accept) begin
                PC_out <= VECTOR_BASE + N'(idx) * N'(VECTOR_STRIDE);
                level <= idx;
            end else if (Branch_taken) PC_out <= Branch_target;
            else PC_out <= PC_out + N'(1);
        end
    end
endmodule

// File: tb/tb_pc_irq_sequencer.sv
// tb_pc_irq_sequencer: directed vectors feed an expectation queue; a negedge monitor pops and compares.
module tb_pc_irq_sequencer;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, br = 1'b0, reti = 1'b0, ic = 1'b0;
    logic [15:0] tgt = '0;
    logic [7:0] inr = '0;
    logic [15:0] pc_out;
    logic [7:0] ack;
    logic in_service, stack_full, stack_error;
    typedef struct {
        logic [15:0] pc;
        logic [7:0]  ack;
        logic        ins, full, err;
        int          tag;
    } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, tag = 0;
    always #5 clk = ~clk;
    pc_irq_sequencer dut (
        .Clock(clk), .Reset(rst), .Stall(stall), .Branch_taken(br), .Branch_target(tgt),
        .Reti(reti), .Inr_Check(ic), .Inr(inr), .PC_out(pc_out), .Irq_ack(ack),
        .In_service(in_service), .Stack_full(stack_full), .Stack_error(stack_error)
    );
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (pc_out !== e.pc || ack !== e.ack || in_service !== e.ins ||
                stack_full !== e.full || stack_error !== e.err) begin
                failures++;
                $display("FAIL step%0d: got pc=%h ack=%b ins=%b full=%b err=%b, want pc=%h ack=%b ins=%b full=%b err=%b",
                         e.tag, pc_out, ack, in_service, stack_full, stack_error,
                         e.pc, e.ack, e.ins, e.full, e.err);
            end
        end
    end
    task automatic expect_now(input logic [15:0] pc, input logic [7:0] a, input logic ins, full, err);
        exp_t e;
        e.pc = pc; e.ack = a; e.ins = ins; e.full = full; e.err = err; e.tag = tag;
        q.push_back(e);
        tag++;
    endtask
    task automatic step(input logic s, b, input logic [15:0] t, input logic r, c, input logic [7:0] irq,
                        input logic [15:0] pc, input logic [7:0] a, input logic ins, full, err);
        stall = s; br = b; tgt = t; reti = r; ic = c; inr = irq;
        expect_now(pc, a, ins, full, err);
        @(posedge clk);
        #1;
    endtask
    // Reset raised between edges must clear the outputs before the next edge
    task automatic areset();
        stall = 0; br = 0; reti = 0; ic = 0; inr = 0;
        #1 rst = 1'b1;
        expect_now(16'h0000, 8'h00, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 16'(i), 0, 0, 0, 0);
        areset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 16'(i), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8'h20, 16'h0003, 8'h20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8'h00, 16'h00FA, 8'h00, 1, 0, 0);
        step(0, 0, 0, 1, 1, 8'h00, 16'h00FB, 8'h00, 1, 0, 0);
        step(0, 0, 0, 0, 1, 8'h00, 16'h0004, 8'h00, 0, 0, 0);
        // nesting: ch5 then ch2; ch6 waits until idle
        step(0, 0, 0, 0, 1, 8'h20, 16'h0005, 8'h20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8'h04, 16'h00FA, 8'h04, 1, 0, 0);
        step(0, 0, 0, 0, 1, 8'h40, 16'h00F4, 8'h00, 1, 0, 0);
        step(0, 0, 0, 1, 1, 8'h40, 16'h00F5, 8'h00, 1, 0, 0);
        step(0, 0, 0, 0, 1, 8'h40, 16'h00FB, 8'h00, 1, 0, 0);
        step(0, 0, 0, 1, 1, 8'h40, 16'h00FC, 8'h00, 1, 0, 0);
        step(0, 0, 0, 0, 1, 8'h40, 16'h0006, 8'h40, 0, 0, 0);
        step(0, 0, 0, 1, 1, 8'h00, 16'h00FC, 8'h00, 1, 0, 0);
        // branch coinciding with an accept returns to the branch target
        step(0, 1, 16'h0040, 0, 1, 8'h01, 16'h0007, 8'h01, 0, 0, 0);
        step(0, 0, 0, 1, 1, 8'h00, 16'h00F0, 8'h00, 1, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00, 16'h0040, 8'h00, 0, 0, 0);
        step(0, 1, 16'h0100, 0, 0, 8'h00, 16'h0041, 8'h00, 0, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00, 16'h0100, 8'h00, 0, 0, 0);
        // fill with ch3,2,1,0
        step(0, 0, 0, 0, 1, 8'h08, 16'h0101, 8'h08, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8'h04, 16'h00F6, 8'h04, 1, 0, 0);
        step(0, 0, 0, 0, 1, 8'h02, 16'h00F4, 8'h02, 1, 0, 0);
        step(0, 0, 0, 0, 1, 8'h01, 16'h00F2, 8'h01, 1, 0, 0);
        step(0, 0, 0, 0, 1, 8'h01, 16'h00F0, 8'h00, 1, 1, 0);
        step(1, 0, 0, 0, 1, 8'h01, 16'h00F1, 8'h00, 1, 1, 0);
        step(1, 0, 0, 1, 1, 8'h01, 16'h00F1, 8'h00, 1, 1, 0);
        step(1, 1, 16'h0200, 0, 1, 8'h01, 16'h00F1, 8'h00, 1, 1, 0);
        step(0, 0, 0, 1, 0, 8'h00, 16'h00F1, 8'h00, 1, 1, 0);
        step(0, 0, 0, 1, 0, 8'h00, 16'h00F3, 8'h00, 1, 0, 0);
        step(0, 0, 0, 1, 0, 8'h00, 16'h00F5, 8'h00, 1, 0, 0);
        step(0, 0, 0, 1, 0, 8'h00, 16'h00F7, 8'h00, 1, 0, 0);
        // Reti on an empty stack sets a sticky error
        step(0, 0, 0, 1, 0, 8'h00, 16'h0102, 8'h00, 0, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00, 16'h0103, 8'h00, 0, 0, 1);
        // fill with ch6,5,4,3; ch0 is held off while full and taken after one Reti
        step(0, 0, 0, 0, 1, 8'h40, 16'h0104, 8'h40, 0, 0, 1);
        step(0, 0, 0, 0, 1, 8'h20, 16'h00FC, 8'h20, 1, 0, 1);
        step(0, 0, 0, 0, 1, 8'h10, 16'h00FA, 8'h10, 1, 0, 1);
        step(0, 0, 0, 0, 1, 8'h08, 16'h00F8, 8'h08, 1, 0, 1);
        step(0, 0, 0, 0, 1, 8'h01, 16'h00F6, 8'h00, 1, 1, 1);
        step(0, 0, 0, 1, 1, 8'h01, 16'h00F7, 8'h00, 1, 1, 1);
        step(0, 0, 0, 0, 1, 8'h01, 16'h00F9, 8'h01, 1, 0, 1);
        step(0, 0, 0, 1, 1, 8'h00, 16'h00F0, 8'h00, 1, 1, 1);
        step(0, 0, 0, 1, 1, 8'h00, 16'h00FA, 8'h00, 1, 0, 1);
        step(0, 0, 0, 1, 1, 8'h00, 16'h00FB, 8'h00, 1, 0, 1);
        step(0, 0, 0, 1, 1, 8'h00, 16'h00FD, 8'h00, 1, 0, 1);
        // global enable low blocks acceptance
        step(0, 0, 0, 0, 0, 8'h01, 16'h0105, 8'h00, 0, 0, 1);
        step(0, 0, 0, 0, 0, 8'h00, 16'h0106, 8'h00, 0, 0, 1);
        areset();
        step(0, 1, 16'hFFFF, 0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00, 16'hFFFF, 8'h00, 0, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
